// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped, write-through cache controller.
package cache_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;
    localparam int TAG_W  = 5;
    localparam int LINES  = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_RD_DATA = 3'd2,
        S_MEM_RD  = 3'd3,
        S_FILL    = 3'd4,
        S_MEM_WR  = 3'd5
    } state_t;

endpackage

// File: rtl/cache_if.sv
// CPU, main-memory, cache-data-memory and statistics signals of the controller.
interface cache_if;
    import cache_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_busy;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic [IDX_W-1:0]  cm_addr;
    logic              cm_wr;
    logic              cm_rd;
    logic [DATA_W-1:0] cm_wdata;
    logic [DATA_W-1:0] cm_rdata;

    logic [7:0]        hit_cnt;
    logic [7:0]        miss_cnt;

    // Controller side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_busy,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output cm_addr, cm_wr, cm_rd, cm_wdata,
        input  cm_rdata,
        output hit_cnt, miss_cnt
    );

    // CPU / memory environment side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_busy,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  cm_addr, cm_wr, cm_rd, cm_wdata,
        output cm_rdata,
        input  hit_cnt, miss_cnt
    );

endinterface

// File: rtl/cache_tag_array.sv
// Tag and valid storage: one write port, combinational read by index.
// Only the valid bits are reset; they alone decide whether a line is resident.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];

    // Valid bits: cleared asynchronously, set when a line is filled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag storage: written alongside the valid bit, never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_valid = r_valid[i_rd_idx];
    assign o_tag   = r_tag[i_rd_idx];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped 8x1-byte cache controller, write-through, no-write-allocate.
// Read hits complete two edges after acceptance via the registered cache RAM;
// misses fetch from main memory, refill the line and return the fetched byte.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    cache_if.slave bus
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic [7:0]        r_hit_cnt;
    logic [7:0]        r_miss_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_valid;
    logic [TAG_W-1:0]  w_tag_rd;
    logic              w_hit;
    logic              w_tag_we;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign w_idx = r_addr[IDX_W-1:0];
    assign w_tag = r_addr[ADDR_W-1:IDX_W];
    assign w_hit = w_valid && (w_tag_rd == w_tag);

    cache_tag_array u_tags (
        .clk      (clk),
        .rst      (rst),
        .i_rd_idx (w_idx),
        .o_valid  (w_valid),
        .o_tag    (w_tag_rd),
        .i_we     (w_tag_we),
        .i_wr_idx (w_idx),
        .i_wr_tag (w_tag)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-state strobes to main memory and cache RAM
    always_comb begin
        w_next         = r_state;
        w_tag_we       = 1'b0;
        bus.cm_addr    = w_idx;
        bus.cm_wr      = 1'b0;
        bus.cm_rd      = 1'b0;
        bus.cm_wdata   = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = r_addr;
        bus.mem_wdata  = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_we) begin
                    // Write-through: update the RAM only if the line is resident
                    if (w_hit) begin
                        bus.cm_wr    = 1'b1;
                        bus.cm_wdata = r_wdata;
                    end
                    w_next = S_MEM_WR;
                end else if (w_hit) begin
                    bus.cm_rd = 1'b1;
                    w_next    = S_RD_DATA;
                end else begin
                    w_next = S_MEM_RD;
                end
            end
            S_RD_DATA: begin
                w_next = S_IDLE;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_tag_we = 1'b1;
                    w_next   = S_FILL;
                end
            end
            S_FILL: begin
                bus.cm_wr    = 1'b1;
                bus.cm_wdata = r_fill;
                w_next       = S_IDLE;
            end
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                if (bus.mem_ack) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Read data, completion pulse and saturating hit/miss statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_LOOKUP: begin
                    if (w_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
                    else       r_miss_cnt <= sat_inc(r_miss_cnt);
                end
                S_RD_DATA: begin
                    r_rdata <= bus.cm_rdata;
                    r_ready <= 1'b1;
                end
                S_MEM_RD: begin
                    if (bus.mem_ack) r_rdata <= bus.mem_rdata;
                end
                S_FILL: begin
                    r_ready <= 1'b1;
                end
                S_MEM_WR: begin
                    if (bus.mem_ack) r_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Request capture in IDLE and fill byte capture on the memory acknowledge
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.cpu_req) begin
            r_addr  <= bus.cpu_addr;
            r_we    <= bus.cpu_we;
            r_wdata <= bus.cpu_wdata;
        end
        if (r_state == S_MEM_RD && bus.mem_ack) begin
            r_fill <= bus.mem_rdata;
        end
    end

    assign bus.cpu_rdata = r_rdata;
    assign bus.cpu_ready = r_ready;
    assign bus.cpu_busy  = (r_state != S_IDLE);
    assign bus.hit_cnt   = r_hit_cnt;
    assign bus.miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: directed scenarios plus randomized accesses, each
// compared against a line-level cache model and a byte-array main memory.
module tb_cache_ctrl;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_if bus();

    cache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Cache data RAM: write on falling edge, registered read on rising edge
    logic [7:0] cmem [8];
    always @(negedge clk) if (bus.cm_wr) cmem[bus.cm_addr] <= bus.cm_wdata;
    always @(posedge clk) if (bus.cm_rd) bus.cm_rdata <= cmem[bus.cm_addr];

    // Reference model state
    logic [7:0] mainmem [256];
    bit         mv [8];
    logic [4:0] mt [8];
    logic [7:0] md [8];
    int         exp_hit, exp_miss;
    logic [7:0] exp_rdata;
    int         tests, fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        exp_hit   = 0;
        exp_miss  = 0;
        exp_rdata = 8'h00;
    endtask

    // One CPU access; starts #1 after a rising edge with the controller idle
    task automatic access(input logic we, input logic [7:0] a, input logic [7:0] d, input int lat);
        int idx = int'(a[2:0]);
        bit hit = mv[idx] && (mt[idx] == a[7:3]);
        int e_lat, e_cmwr, e_cmrd, e_memcyc;
        logic [7:0] e_cmwr_d;
        int n = 0, cmwr_n = 0, cmrd_n = 0, memk = 0, both = 0;
        logic [2:0] cmwr_i = '0, cmrd_i = '0;
        logic [7:0] cmwr_d = '0, m_addr = '0, m_wd = '0;
        logic m_we = 1'b0;
        bit done = 0;

        e_cmwr_d = 8'h00;
        if (!we && hit) begin
            e_lat = 2; e_cmwr = 0; e_cmrd = 1; e_memcyc = 0;
            exp_rdata = md[idx];
        end else if (!we) begin
            e_lat = lat + 2; e_cmwr = 1; e_cmrd = 0; e_memcyc = lat;
            e_cmwr_d  = mainmem[a];
            exp_rdata = mainmem[a];
            mv[idx] = 1'b1; mt[idx] = a[7:3]; md[idx] = mainmem[a];
        end else begin
            e_lat = lat + 1; e_cmrd = 0; e_memcyc = lat;
            e_cmwr = hit ? 1 : 0;
            e_cmwr_d = d;
            if (hit) md[idx] = d;
            mainmem[a] = d;
        end
        if (hit) exp_hit  = (exp_hit  < 255) ? exp_hit  + 1 : 255;
        else     exp_miss = (exp_miss < 255) ? exp_miss + 1 : 255;

        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        chk("busy_after_accept", bus.cpu_busy, 1);

        while (!done && n < 40) begin
            if (bus.cm_wr && bus.cm_rd) both++;
            if (bus.cm_wr) begin cmwr_n++; cmwr_i = bus.cm_addr; cmwr_d = bus.cm_wdata; end
            if (bus.cm_rd) begin cmrd_n++; cmrd_i = bus.cm_addr; end
            if (bus.mem_req) begin
                memk++;
                m_addr = bus.mem_addr; m_we = bus.mem_we; m_wd = bus.mem_wdata;
                if (memk == lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mainmem[bus.mem_addr];
                end
            end
            if (bus.cpu_ready) done = 1;
            else begin
                @(posedge clk); #1;
                bus.mem_ack = 1'b0;
                n++;
            end
        end
        bus.mem_ack = 1'b0;

        chk("completed", done, 1);
        chk("latency", n, e_lat);
        chk("busy_at_ready", bus.cpu_busy, 0);
        chk("cpu_rdata", bus.cpu_rdata, exp_rdata);
        chk("hit_cnt", bus.hit_cnt, exp_hit);
        chk("miss_cnt", bus.miss_cnt, exp_miss);
        chk("cm_wr_count", cmwr_n, e_cmwr);
        if (e_cmwr == 1) begin
            chk("cm_wr_idx", cmwr_i, idx);
            chk("cm_wr_data", cmwr_d, e_cmwr_d);
        end
        chk("cm_rd_count", cmrd_n, e_cmrd);
        if (e_cmrd == 1) chk("cm_rd_idx", cmrd_i, idx);
        chk("mem_req_cycles", memk, e_memcyc);
        if (e_memcyc > 0) begin
            chk("mem_addr", m_addr, a);
            chk("mem_we", m_we, we);
            if (we) chk("mem_wdata", m_wd, d);
        end
        chk("cm_rd_wr_overlap", both, 0);
    endtask

    initial begin
        tests = 0; fails = 0;
        for (int i = 0; i < 256; i++) mainmem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) cmem[i] = 8'($urandom);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.cm_rdata = '0;
        model_clear();

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", bus.cpu_busy, 0);
        chk("rst_ready", bus.cpu_ready, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_cm_wr", bus.cm_wr, 0);
        chk("rst_cm_rd", bus.cm_rd, 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_hit", bus.hit_cnt, 0);
        chk("rst_miss", bus.miss_cnt, 0);

        // Cold miss, then hit, on 0x2A
        mainmem[8'h2A] = 8'h5C;
        access(1'b0, 8'h2A, 8'h00, 3);
        chk("first_miss_data", bus.cpu_rdata, 8'h5C);
        access(1'b0, 8'h2A, 8'h00, 1);
        chk("first_hit_cnt", bus.hit_cnt, 1);

        // Conflict on index 2
        access(1'b0, 8'h4A, 8'h00, 2);
        access(1'b0, 8'h2A, 8'h00, 2);
        chk("conflict_miss_cnt", bus.miss_cnt, 3);

        // Write hit, write miss, read after write miss
        access(1'b0, 8'h4A, 8'h00, 1);
        access(1'b1, 8'h4A, 8'h77, 2);
        access(1'b0, 8'h4A, 8'h00, 1);
        chk("write_hit_readback", bus.cpu_rdata, 8'h77);
        access(1'b1, 8'h13, 8'h11, 1);
        access(1'b0, 8'h13, 8'h00, 2);
        chk("write_miss_readback", bus.cpu_rdata, 8'h11);

        // Stray acknowledge while idle
        bus.mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        chk("stray_ack_busy", bus.cpu_busy, 0);
        chk("stray_ack_ready", bus.cpu_ready, 0);

        // Reset in the middle of a memory read
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h2A;
        @(posedge clk); #1 bus.cpu_req = 1'b0;
        for (int k = 0; k < 10 && !bus.mem_req; k++) begin @(posedge clk); #1; end
        chk("midrd_mem_req", bus.mem_req, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrd_rst_mem_req", bus.mem_req, 0);
        chk("midrd_rst_busy", bus.cpu_busy, 0);
        chk("midrd_rst_hit", bus.hit_cnt, 0);
        chk("midrd_rst_miss", bus.miss_cnt, 0);
        chk("midrd_rst_rdata", bus.cpu_rdata, 0);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        access(1'b0, 8'h2A, 8'h00, 2);
        chk("post_rst_miss", bus.miss_cnt, 1);

        // Randomized accesses over a small address pool
        for (int i = 0; i < 60; i++) begin
            access(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 23)),
                   8'($urandom), int'($urandom_range(1, 4)));
        end

        // Hit counter saturation
        access(1'b0, 8'h2A, 8'h00, 1);
        for (int i = 0; i < 300; i++) access(1'b0, 8'h2A, 8'h00, 1);
        chk("hit_saturated", bus.hit_cnt, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001: The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002: clk  input  1  rising-edge clock for all state in this block.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: cpu_req / cpu_we / cpu_addr[7:0] / cpu_wdata[7:0]  input  1/1/8/8  CPU request: valid, write-enable, byte address (tag=[7:3], index=[2:0]), write data.
REQ-005: cpu_rdata / cpu_ready / cpu_busy  output  8/1/1  read data, one-cycle completion pulse, controller-not-idle flag.
REQ-006: mem_req / mem_we / mem_addr[7:0] / mem_wdata[7:0]  output  1/1/8/8  main-memory request, held until acknowledged.
REQ-007: mem_rdata[7:0] / mem_ack  input  8/1  main-memory read data and acknowledge, sampled together.
REQ-008: cm_addr[2:0] / cm_wr / cm_rd / cm_wdata[7:0]  output  3/1/1/8  drive to the 8x8 cache data memory (writes on falling edge of the cycle cm_wr is high; read data registered on the next rising edge).
REQ-009: cm_rdata[7:0]  input  8  registered read data from the cache data memory.
REQ-010: hit_cnt[7:0] / miss_cnt[7:0]  output  8/8  saturating lookup statistics.

Function
REQ-011: Organisation SHALL be direct-mapped, 8 lines x 1 byte, write-through, no-write-allocate.
REQ-012: FSM states SHALL be IDLE, LOOKUP, RD_DATA, MEM_RD, FILL, MEM_WR; cpu_busy = (state != IDLE).
REQ-013: IDLE: cpu_req sampled high SHALL latch addr/we/wdata and go to LOOKUP; cpu_req while busy SHALL be ignored.
REQ-014: LOOKUP: hit = valid[index] && tag[index]==addr[7:3]; read hit -> cm_rd=1, cm_addr=index, next RD_DATA; read miss -> MEM_RD; any write -> MEM_WR, with cm_wr=1, cm_wdata=wdata in LOOKUP only on write hit.
REQ-015: RD_DATA: cpu_rdata <= cm_rdata, cpu_ready pulsed, next IDLE; read-hit completion SHALL occur on the 2nd rising edge after acceptance.
REQ-016: MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr until mem_ack; on ack edge: fill register and cpu_rdata <= mem_rdata, tag[index] <= addr[7:3], valid[index] <= 1, next FILL.
REQ-017: FILL: cm_wr=1, cm_addr=index, cm_wdata=fill register; on exit cpu_ready pulsed, next IDLE; a valid line with a different tag SHALL be silently replaced (no writeback needed).
REQ-018: MEM_WR: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched; on ack edge cpu_ready pulsed, next IDLE; write miss SHALL not change tag/valid or cache data.
REQ-019: mem_ack while mem_req=0 SHALL be ignored; mem_req SHALL never drop before ack except on reset.
REQ-020: hit_cnt/miss_cnt SHALL increment once per LOOKUP (reads and writes) and saturate at 255.
REQ-021: A new cpu_req SHALL be accepted in the IDLE cycle in which cpu_ready is high.
REQ-022: cm_rd and cm_wr SHALL never be high in the same cycle; all cm_*/mem_* strobes low outside the states above.

Reset
REQ-023: rst SHALL immediately force state IDLE, all valid bits 0, cpu_rdata/hit_cnt/miss_cnt 0, and cpu_ready/cpu_busy/mem_req/mem_we/cm_wr/cm_rd 0, including mid-transaction (in-flight memory access abandoned).
REQ-024: Tag contents need not be reset; valid bits alone define residency.

Structure
REQ-025: Shared package cache_pkg SHALL hold ADDR_W=8, DATA_W=8, IDX_W=3, TAG_W=5, LINES=8 and the FSM state encoding.
REQ-026: Tag/valid storage SHALL be a sub-module cache_tag_array (async clear of valid, one write port, combinational read by index).

Verification
REQ-027: After reset, read 0x2A, mem_ack 3 cycles later with 0x5C -> mem_addr=0x2A, cm_wr at index 2 with 0x5C, cpu_rdata=0x5C, miss_cnt=1.
REQ-028: Read 0x2A again -> no mem_req, cm_rd at index 2, cpu_ready 2 edges after acceptance, cpu_rdata=0x5C, hit_cnt=1.
REQ-029: Read 0x4A (same index, tag differs) -> miss and replace; subsequent read 0x2A misses again; miss_cnt=3.
REQ-030: Write 0x77 to resident 0x4A -> cm_wr with 0x77 and mem write 0x4A/0x77; write 0x11 to 0x13 (miss) -> mem write only, no cm_wr; read 0x13 then misses.
REQ-031: Assert rst during MEM_RD -> mem_req low immediately, cpu_busy=0, counters 0; next read of 0x2A misses.
REQ-032: 300 consecutive read hits -> hit_cnt holds 255.
